serial_2wire_regwriter: RTL

Register-write sequencer sitting directly upstream of `serial_2wire`. It accepts (register, value) byte pairs from the control logic through a valid/ready port, buffers them in a small FIFO, and drives `serial_2wire` (write mode) so that each pair goes out as one bus transaction: register byte, then value byte. It replaces the hand-written byte sequencing in the control logic and counts bus errors.

---
 rtl/serial_2wire_regwriter_pkg.sv | 25 ++
 rtl/serial_2wire_regwriter_fifo_sync.sv | 49 ++++
 rtl/serial_2wire_regwriter.sv | 118 +++++++++++
 3 files changed

// File: rtl/serial_2wire_regwriter_pkg.sv
// Shared types for the serial_2wire register-write sequencer.
package serial_2wire_regwriter_pkg;

  localparam int unsigned REGWR_BITS = 8;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_SEND_REG,
    ST_SEND_DATA,
    ST_WAIT_DONE
  } t_regwr_state;

  // One queued bus write: register byte in the upper half, value byte below.
  typedef struct packed {
    logic [REGWR_BITS-1:0] regaddr;
    logic [REGWR_BITS-1:0] val;
  } t_regwr_pair;

  // True while a byte of the current pair is being handed to serial_2wire.
  function automatic logic is_sending(input t_regwr_state s);
    return (s == ST_SEND_REG) || (s == ST_SEND_DATA);
  endfunction

endpackage

// File: rtl/serial_2wire_regwriter_fifo_sync.sv
// Synchronous FIFO with wrap-bit pointers; exposes head, level, full, empty.
module fifo_sync #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/serial_2wire_regwriter.sv
// Sequences buffered (register, value) pairs onto serial_2wire as write transactions.
module serial_2wire_regwriter
  import serial_2wire_regwriter_pkg::*;
#(
  parameter int unsigned BITS       = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ERR_BITS   = 8
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic                        in_cmd_valid,
  input  logic [BITS-1:0]             in_cmd_reg,
  input  logic [BITS-1:0]             in_cmd_val,
  output logic                        out_cmd_ready,
  output logic                        out_serial_rst,
  output logic                        out_serial_enable,
  output logic [BITS-1:0]             out_serial_data,
  input  logic                        in_serial_ready,
  input  logic                        in_serial_next,
  input  logic                        in_serial_err,
  output logic                        out_busy,
  output logic [$clog2(FIFO_DEPTH):0] out_level,
  output logic [ERR_BITS-1:0]         out_err_count
);

  t_regwr_state      state;
  logic              next_prev;
  logic              next_rise;
  logic              sending;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [2*BITS-1:0] head;
  logic [BITS-1:0]   head_reg;
  logic [BITS-1:0]   head_val;

  assign head_reg  = head[2*BITS-1:BITS];
  assign head_val  = head[BITS-1:0];
  assign sending   = is_sending(state);
  assign next_rise = in_serial_next && !next_prev;

  assign out_cmd_ready = !fifo_full;
  assign push          = in_cmd_valid && !fifo_full;
  // The head stays in place for the whole transaction and leaves only once it is finished or aborted.
  assign pop = (sending && in_serial_err) || ((state == ST_SEND_DATA) && next_rise);

  fifo_sync #(
    .WIDTH (2*BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (in_clk),
    .rst       (in_rst),
    .push      (push),
    .push_data ({in_cmd_reg, in_cmd_val}),
    .pop       (pop),
    .head      (head),
    .level     (out_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Previous in_serial_next, so a held-high strobe counts as a single edge.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) next_prev <= 1'b0;
    else        next_prev <= in_serial_next;
  end

  // Transaction sequencing; an error while sending aborts the pair.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state <= ST_RESET;
    end else begin
      case (state)
        ST_RESET:     state <= ST_IDLE;
        ST_IDLE:      if (!fifo_empty && in_serial_ready) state <= ST_SEND_REG;
        ST_SEND_REG: begin
          if (in_serial_err)  state <= ST_WAIT_DONE;
          else if (next_rise) state <= ST_SEND_DATA;
        end
        ST_SEND_DATA: if (in_serial_err || next_rise) state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (in_serial_ready) state <= ST_IDLE;
        default:      state <= ST_RESET;
      endcase
    end
  end

  // Saturating count of bus errors seen while a pair is in flight.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_err_count <= '0;
    end else if (sending && in_serial_err && (out_err_count != '1)) begin
      out_err_count <= out_err_count + ERR_BITS'(1);
    end
  end

  // Output decode of state and FIFO head; serial reset stays low while our own reset is held.
  always_comb begin
    out_serial_rst    = 1'b0;
    out_serial_enable = 1'b0;
    out_serial_data   = '0;
    case (state)
      ST_RESET:     out_serial_rst = !in_rst;
      ST_SEND_REG: begin
        out_serial_enable = 1'b1;
        out_serial_data   = head_reg;
      end
      ST_SEND_DATA: begin
        out_serial_enable = 1'b1;
        out_serial_data   = head_val;
      end
      default: ;
    endcase
  end

  assign out_busy = (state != ST_IDLE) || !fifo_empty;

endmodule
